mem_stage_sram_ctrl: RTL and testbench
======================================

# mem_stage_sram_ctrl

Memory-stage responder for the execute stage's load/store requests. It takes the ALU-computed address, store data, and read/write enables registered out of the execute stage. Each 32-bit access is performed as two sequential 16-bit accesses to the external SRAM. While an access is in flight, `ready` is deasserted so the hazard/freeze logic stalls the whole pipeline.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `PHASE_CYCLES`, 2: cycles spent on each 16-bit half access (legal range ≥1).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_en`  in  1  load request (from EXE/MEM register `MEM_R_EN`).
- `wr_en`  in  1  store request (from EXE/MEM register `MEM_W_EN`).
- `address`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (forwarded Rm value).
- `rdata`  out  32  load result to the write-back path.
- `ready`  out  1  high = no request pending or request completing this cycle; low = freeze the pipeline.
- `SRAM_ADDR`  out  18  half-word address to the SRAM.
- `SRAM_DQ`  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.
- `SRAM_WE_N`  out  1  active-low SRAM write strobe.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- **IDLE**
  - If `wr_en` or `rd_en` is high, latch `address`, `wdata` and the op into internal registers.
  - If both are high, the op is a write.
  - Clear the phase counter and go to LOW.
  - Otherwise stay in IDLE.
- **LOW** (half-word 0)
  - Stays for `PHASE_CYCLES` cycles, then goes to HIGH.
  - `SRAM_ADDR = {word[16:0],1'b0}`.
  - On a write: `SRAM_DQ = wdata_q[15:0]`, `SRAM_WE_N = 0`.
  - On a read: `SRAM_DQ` high-Z; `rdata[15:0]` captures `SRAM_DQ` on the last cycle of the phase.
- **HIGH** (half-word 1)
  - Stays for `PHASE_CYCLES` cycles, then goes to DONE.
  - `SRAM_ADDR = {word[16:0],1'b1}`.
  - Write data is `wdata_q[31:16]`.
  - On a read, `rdata[31:16]` captures on the last cycle.
- **DONE**: one cycle, then IDLE unconditionally; SRAM idle.
- Word address: `word = (address_q − BASE_ADDR) >> 2`, 32-bit unsigned subtract, truncated to 17 bits.
  - Addresses outside the window wrap modulo 2^17 words; no error is flagged.
  - `address[1:0]` is ignored.
- `ready` (combinational):
  - 0 when state is LOW or HIGH.
  - 0 when state is IDLE and `(rd_en|wr_en)`.
  - 1 in DONE, and in IDLE with no request.
- The in-flight op always completes from latched values. Input changes after acceptance are ignored.
- `rdata` holds its last value until the next read overwrites it. Writes never change `rdata`.
- SRAM idle values (IDLE/DONE): `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `SRAM_ADDR` = last driven value (0 after reset).

## Timing
- Reset values:
  - state IDLE, counter 0.
  - `rdata = 0`, `SRAM_ADDR = 0`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z.
  - `ready = 1` while no request is present.
- Latency: a request seen at cycle 0 (edge into LOW at end of cycle 0) gives:
  - LOW at cycles 1..P, HIGH at cycles P+1..2P, DONE at cycle 2P+1.
  - `ready` is low for cycles 0..2P and high at cycle 2P+1; with P=2, ready is low for 5 cycles.
- `rdata` is valid from DONE onward. The pipeline register samples it on the edge ending DONE.
- Back-to-back: the pipeline advances at the DONE edge. A new request visible in the following IDLE cycle is accepted there; there is 1 IDLE cycle between ops, with `ready` low in it.
- `SRAM_WE_N` is low continuously for all 2P write-phase cycles. `SRAM_ADDR` changes at the LOW→HIGH edge.
- Reset mid-operation:
  - Abort at the next edge and return to IDLE.
  - `SRAM_WE_N = 1`, bus released.
  - The partially written word is left as-is; a partially captured `rdata` is cleared to 0.

## Test plan
- **Reset/idle:** assert `rst` 2 cycles, no request → `ready = 1`, `SRAM_WE_N = 1`, `SRAM_DQ` high-Z, `rdata = 0`.
- **Write then read:**
  - Write `address = 1032`, `wdata = 0xDEADBEEF` → `SRAM_ADDR = 4` with DQ `0xBEEF`, then `SRAM_ADDR = 5` with DQ `0xDEAD`, `WE_N` low 4 cycles, `ready` low 5 cycles.
  - Then read 1032 → `rdata = 0xDEADBEEF` at DONE.
- **Boundary:** `address = 1024` → SRAM addresses 0/1. `address = 1024 + 4*131071` → 0x3FFFE/0x3FFFF. `address = 1020` → word wraps to 0x1FFFF, SRAM 0x3FFFE/0x3FFFF.
- **Simultaneous:** `rd_en = wr_en = 1`, `wdata = 0x12345678` → write performed, `rdata` unchanged. A subsequent read returns `0x12345678`.
- **Back-to-back and input churn:**
  - Two reads held by a frozen pipeline → each takes 6 cycles, with exactly one IDLE cycle between them.
  - Toggle `rd_en` low during HIGH → op still completes with correct `rdata`.
- **Reset mid-op:** assert `rst` during HIGH of a write → next cycle IDLE, `WE_N = 1`, bus high-Z. Reading back shows the low half updated and the high half unchanged.

Source files
------------

// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage load/store responder: each 32-bit access runs as two 16-bit SRAM half accesses,
// holding ready low so the pipeline freezes until the access completes.
module mem_stage_sram_ctrl #(
    parameter int unsigned BASE_ADDR    = 1024,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [17:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_WE_N
);

    localparam int unsigned CntW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(PHASE_CYCLES - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLow  = 2'd1;
    localparam logic [1:0] StHigh = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [16:0]     word_q, word_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [17:0]     sram_addr_q, sram_addr_d;

    logic phase_last;
    logic in_phase;
    logic drive;

    // Window-relative word index; out-of-window addresses simply wrap.
    function automatic logic [16:0] word_of(input logic [31:0] a);
        return 17'((a - 32'(BASE_ADDR)) >> 2);
    endfunction

    assign phase_last = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        case (state_q)
            StIdle: begin
                if (rd_en || wr_en) begin
                    wr_d        = wr_en;
                    word_d      = word_of(address);
                    wdata_d     = wdata;
                    cnt_d       = '0;
                    sram_addr_d = {word_of(address), 1'b0};
                    state_d     = StLow;
                end
            end
            StLow: begin
                if (phase_last) begin
                    if (!wr_q) rdata_d[15:0] = SRAM_DQ;
                    cnt_d       = '0;
                    sram_addr_d = {word_q, 1'b1};
                    state_d     = StHigh;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHigh: begin
                if (phase_last) begin
                    if (!wr_q) rdata_d[31:16] = SRAM_DQ;
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
        end
    end

    assign in_phase  = (state_q == StLow) || (state_q == StHigh);
    assign drive     = in_phase && wr_q;
    assign SRAM_WE_N = ~drive;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_DQ   = drive ? ((state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;
    assign rdata     = rdata_q;
    // A request sitting in IDLE freezes the pipeline until it is accepted and finished.
    assign ready     = !(in_phase || ((state_q == StIdle) && (rd_en || wr_en)));

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: SRAM model plus a word-level reference memory.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned Base = 1024;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_WE_N;

    mem_stage_sram_ctrl #(.BASE_ADDR(Base), .PHASE_CYCLES(P)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
        .rdata(rdata), .ready(ready), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
        .SRAM_WE_N(SRAM_WE_N)
    );

    always #5 clk = ~clk;

    // External SRAM: drives the bus whenever not being written; write cycles under reset are dropped.
    bit [15:0] sram [0:262143];
    assign SRAM_DQ = SRAM_WE_N ? sram[SRAM_ADDR] : 16'hzzzz;
    always @(posedge clk) if (!SRAM_WE_N && !rst) sram[SRAM_ADDR] <= SRAM_DQ;

    // Reference: word-addressed memory and the expected rdata register.
    bit [31:0]   ref_mem [0:131071];
    logic [31:0] exp_rdata = '0;

    int errors = 0;
    int checks = 0;

    logic [17:0] addr_log [64];
    logic        we_log [64];
    logic [15:0] dq_log [64];
    int          n_low;
    logic [31:0] rdata_done;

    function automatic logic [16:0] exp_word(input logic [31:0] a);
        logic [31:0] diff;
        diff = a - Base;
        return diff[18:2];
    endfunction

    // Presents a request and records bus activity each cycle until ready rises (DONE).
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int churn_at);
        int  cyc;
        bit  done;
        @(negedge clk);
        rd_en = rd; wr_en = wr; address = a; wdata = d;
        #1;
        cyc = 0; n_low = 0; done = 0;
        while (!done) begin
            addr_log[cyc] = SRAM_ADDR;
            we_log[cyc]   = SRAM_WE_N;
            dq_log[cyc]   = SRAM_DQ;
            if (ready) begin
                done = 1;
            end else begin
                n_low++;
                if (cyc == churn_at) begin
                    rd_en = 1'b0; wr_en = 1'b0; address = $urandom; wdata = $urandom;
                end
                if (cyc >= 40) begin
                    errors++; checks++;
                    $display("FAIL op_timeout: ready still low after %0d cycles, required by %0d",
                             cyc, 2 * P + 1);
                    done = 1;
                end else begin
                    @(negedge clk); #1;
                    cyc++;
                end
            end
        end
        rdata_done = rdata;
    endtask

    task automatic release_req();
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        checks++;
        if (SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", SRAM_WE_N); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++;
        if (SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", SRAM_ADDR); end
        checks++;
        if (SRAM_DQ !== sram[SRAM_ADDR]) begin
            errors++; $display("FAIL reset_bus_free: got %h want %h", SRAM_DQ, sram[SRAM_ADDR]);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        logic [16:0] w;
        w = exp_word(32'd1032);
        do_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, -1);
        checks++;
        if (n_low !== 2 * P + 1) begin errors++; $display("FAIL wr_ready_low: got %0d want %0d", n_low, 2 * P + 1); end
        for (int i = 1; i <= 2 * P; i++) begin
            logic [17:0] ea;
            logic [15:0] ed;
            ea = (i <= P) ? 18'd4 : 18'd5;
            ed = (i <= P) ? 16'hBEEF : 16'hDEAD;
            checks++;
            if (addr_log[i] !== ea || we_log[i] !== 1'b0 || dq_log[i] !== ed) begin
                errors++;
                $display("FAIL wr_phase cyc %0d: addr=%h we_n=%b dq=%h want addr=%h we_n=0 dq=%h",
                         i, addr_log[i], we_log[i], dq_log[i], ea, ed);
            end
        end
        checks++;
        if (we_log[0] !== 1'b1 || we_log[2 * P + 1] !== 1'b1) begin
            errors++; $display("FAIL wr_we_window: we_n idle=%b done=%b want 1/1", we_log[0], we_log[2 * P + 1]);
        end
        ref_mem[w] = 32'hDEADBEEF;
        release_req();
        do_op(1'b1, 1'b0, 32'd1032, 32'h0, -1);
        exp_rdata = ref_mem[w];
        checks++;
        if (rdata_done !== exp_rdata) begin errors++; $display("FAIL rd_data: got %h want %h", rdata_done, exp_rdata); end
        checks++;
        if (we_log[1] !== 1'b1 || we_log[P + 1] !== 1'b1) begin
            errors++; $display("FAIL rd_we_n: got %b/%b want 1/1", we_log[1], we_log[P + 1]);
        end
        release_req();
    endtask

    task automatic test_boundary();
        logic [31:0] addrs [3];
        logic [17:0] lo [3];
        logic [31:0] d;
        addrs[0] = 32'd1024;             lo[0] = 18'h00000;
        addrs[1] = 32'd1024 + 4 * 131071; lo[1] = 18'h3FFFE;
        addrs[2] = 32'd1020;             lo[2] = 18'h3FFFE;
        for (int k = 0; k < 3; k++) begin
            d = $urandom;
            do_op(1'b0, 1'b1, addrs[k], d, -1);
            checks++;
            if (addr_log[1] !== lo[k] || addr_log[P + 1] !== (lo[k] | 18'h1)) begin
                errors++;
                $display("FAIL boundary_addr %h: got %h/%h want %h/%h", addrs[k], addr_log[1],
                         addr_log[P + 1], lo[k], lo[k] | 18'h1);
            end
            ref_mem[exp_word(addrs[k])] = d;
            release_req();
            do_op(1'b1, 1'b0, addrs[k], 32'h0, -1);
            exp_rdata = ref_mem[exp_word(addrs[k])];
            checks++;
            if (rdata_done !== exp_rdata) begin
                errors++; $display("FAIL boundary_read %h: got %h want %h", addrs[k], rdata_done, exp_rdata);
            end
            release_req();
        end
    endtask

    task automatic test_simultaneous();
        do_op(1'b1, 1'b1, 32'd2048, 32'h12345678, -1);
        checks++;
        if (rdata_done !== exp_rdata) begin errors++; $display("FAIL simul_rdata_kept: got %h want %h", rdata_done, exp_rdata); end
        checks++;
        if (we_log[1] !== 1'b0) begin errors++; $display("FAIL simul_is_write: we_n got %b want 0", we_log[1]); end
        ref_mem[exp_word(32'd2048)] = 32'h12345678;
        release_req();
        do_op(1'b1, 1'b0, 32'd2048, 32'h0, -1);
        exp_rdata = ref_mem[exp_word(32'd2048)];
        checks++;
        if (rdata_done !== 32'h12345678) begin errors++; $display("FAIL simul_readback: got %h want 12345678", rdata_done); end
        release_req();
    endtask

    task automatic test_back_to_back();
        do_op(1'b1, 1'b0, 32'd1032, 32'h0, -1);
        checks++;
        if (n_low + 1 !== 6 || rdata_done !== ref_mem[exp_word(32'd1032)]) begin
            errors++; $display("FAIL b2b_first: cycles=%0d rdata=%h want 6 %h", n_low + 1, rdata_done,
                               ref_mem[exp_word(32'd1032)]);
        end
        do_op(1'b1, 1'b0, 32'd2048, 32'h0, -1);
        exp_rdata = ref_mem[exp_word(32'd2048)];
        checks++;
        if (n_low + 1 !== 6 || rdata_done !== exp_rdata) begin
            errors++; $display("FAIL b2b_second: cycles=%0d rdata=%h want 6 %h", n_low + 1, rdata_done, exp_rdata);
        end
        checks++;
        if (addr_log[1] !== {exp_word(32'd2048), 1'b0}) begin
            errors++; $display("FAIL b2b_second_addr: got %h want %h", addr_log[1], {exp_word(32'd2048), 1'b0});
        end
        release_req();
    endtask

    task automatic test_churn();
        logic [31:0] d;
        do_op(1'b1, 1'b0, 32'd1032, 32'h0, P + 1);
        exp_rdata = ref_mem[exp_word(32'd1032)];
        checks++;
        if (rdata_done !== exp_rdata) begin errors++; $display("FAIL churn_read: got %h want %h", rdata_done, exp_rdata); end
        d = $urandom;
        do_op(1'b0, 1'b1, 32'd3000, d, 1);
        ref_mem[exp_word(32'd3000)] = d;
        release_req();
        do_op(1'b1, 1'b0, 32'd3000, 32'h0, -1);
        exp_rdata = ref_mem[exp_word(32'd3000)];
        checks++;
        if (rdata_done !== exp_rdata) begin errors++; $display("FAIL churn_write: got %h want %h", rdata_done, exp_rdata); end
        release_req();
    endtask

    task automatic test_reset_midop();
        logic [31:0] old_v;
        logic [16:0] w;
        w = exp_word(32'd4096);
        old_v = 32'hA5A5_1111;
        do_op(1'b0, 1'b1, 32'd4096, old_v, -1);
        ref_mem[w] = old_v;
        release_req();
        @(negedge clk);
        wr_en = 1'b1; address = 32'd4096; wdata = 32'h5A5A_2222;
        repeat (P + 1) @(negedge clk);
        #1;
        checks++;
        if (SRAM_WE_N !== 1'b0 || SRAM_ADDR !== {w, 1'b1}) begin
            errors++; $display("FAIL midop_in_high: we_n=%b addr=%h want 0 %h", SRAM_WE_N, SRAM_ADDR, {w, 1'b1});
        end
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (SRAM_WE_N !== 1'b1 || ready !== 1'b1 || rdata !== 32'h0) begin
            errors++; $display("FAIL midop_abort: we_n=%b ready=%b rdata=%h want 1 1 0", SRAM_WE_N, ready, rdata);
        end
        checks++;
        if (SRAM_DQ !== sram[SRAM_ADDR]) begin
            errors++; $display("FAIL midop_bus_free: got %h want %h", SRAM_DQ, sram[SRAM_ADDR]);
        end
        rst = 1'b0;
        exp_rdata = 32'h0;
        ref_mem[w] = {old_v[31:16], 16'h2222};
        do_op(1'b1, 1'b0, 32'd4096, 32'h0, -1);
        exp_rdata = ref_mem[w];
        checks++;
        if (rdata_done !== exp_rdata) begin errors++; $display("FAIL midop_readback: got %h want %h", rdata_done, exp_rdata); end
        release_req();
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] a, d;
        logic [16:0] w;
        int          kind;
        for (int k = 0; k < 4; k++) pool[k] = Base + 4 * $urandom_range(0, 131071) + $urandom_range(0, 3);
        pool[4] = $urandom;
        pool[5] = $urandom_range(0, Base - 1);
        for (int n = 0; n < 24; n++) begin
            a = pool[$urandom_range(0, 5)];
            d = $urandom;
            kind = $urandom_range(0, 2);
            w = exp_word(a);
            do_op(kind != 1, kind != 0, a, d, -1);
            checks++;
            if (n_low !== 2 * P + 1 || addr_log[1] !== {w, 1'b0} || addr_log[P + 1] !== {w, 1'b1}) begin
                errors++; $display("FAIL rand_timing a=%h: low=%0d addr=%h/%h want %0d %h/%h", a, n_low,
                                   addr_log[1], addr_log[P + 1], 2 * P + 1, {w, 1'b0}, {w, 1'b1});
            end
            if (kind != 0) ref_mem[w] = d;
            else exp_rdata = ref_mem[w];
            checks++;
            if (rdata_done !== exp_rdata) begin
                errors++; $display("FAIL rand_rdata a=%h kind=%0d: got %h want %h", a, kind, rdata_done, exp_rdata);
            end
            release_req();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_simultaneous();
        test_back_to_back();
        test_churn();
        test_reset_midop();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
